wb_host_bridge: RTL and testbench
=================================

WB_HOST_BRIDGE -- requirements
Module: wb_host_bridge

Interface
REQ-001 Parameter MEM_AW, default 12, SHALL set the BRAM byte-address width; the BRAM window is 0x0000_0000..2^MEM_AW-1.
REQ-002 Parameter REG_BASE, default 32'h0000_1000, SHALL set the base of a 256-byte register window.
REQ-003 Parameter TIMEOUT, default 255, SHALL set the maximum number of cycles spent waiting for reg_ack.
REQ-004 The block SHALL have one clock and an asynchronous, active-high reset, with ports:
- sys_clk  in  1  clock
- reset  in  1  async active-high reset
- wbm_cyc_o  in  1  cycle
- wbm_stb_o  in  1  strobe
- wbm_adr_o  in  32  byte address
- wbm_we_o  in  1  write
- wbm_dat_o  in  32  write data
- wbm_sel_o  in  4  byte enables
- wbm_dat_i  out  32  read data
- wbm_ack_i  out  1  acknowledge
- wbm_err_i  out  1  error
- mem_wren  out  4  BRAM byte write enables
- mem_addr  out  MEM_AW-2  BRAM word address
- mem_wdata  out  32  BRAM write data
- mem_rdata  in  32  BRAM read data, valid one cycle after address
- reg_cs  out  1  register select
- reg_wr  out  1  register write
- reg_addr  out  8  register byte offset
- reg_be  out  4  register byte enables
- reg_wdata  out  32  register write data
- reg_rdata  in  32  register read data
- reg_ack  in  1  register access done

Function
REQ-005 The FSM SHALL have five states: IDLE, MEM, REG, ACK and ERR.
REQ-006 In IDLE, cyc&stb SHALL latch adr, we, dat and sel, then decode to: BRAM window -> MEM; register window -> REG; any other address -> ERR.
REQ-007 In MEM, the block SHALL drive mem_addr=adr[MEM_AW-1:2] and mem_wdata, with mem_wren=sel when we=1 and 4'b0 otherwise, then go to ACK unconditionally.
REQ-008 In REG, the block SHALL hold reg_cs=1, reg_wr=we and reg_addr/reg_be/reg_wdata from the latch.
REQ-009 In REG, a cycle with reg_ack=1 SHALL capture reg_rdata and go to ACK.
REQ-010 In ACK, the block SHALL set wbm_ack_i=1 for exactly one cycle.
REQ-011 In ACK, wbm_dat_i SHALL equal mem_rdata for a BRAM access or the captured reg_rdata for a register access, and SHALL be 0 for writes.
REQ-012 After ACK, the FSM SHALL return to IDLE.
REQ-013 In ERR, the block SHALL set wbm_err_i=1 for exactly one cycle, keep wbm_dat_i=0, then return to IDLE.
REQ-014 Outside ACK and ERR, wbm_ack_i, wbm_err_i and wbm_dat_i SHALL be 0.
REQ-015 Outside their own states, mem_wren and reg_cs SHALL be 0.
REQ-016 BRAM access latency SHALL be fixed: stb sampled at edge N gives ack high in cycle N+2.
REQ-017 A new request SHALL NOT be accepted in the ACK or ERR cycle; the IDLE re-sample avoids double-acking a stb still held high.
REQ-018 If cyc drops while in REG, the FSM SHALL go to IDLE with no ack or err; a reg_ack arriving in that same cycle SHALL be ignored.
REQ-019 Address decode SHALL compare all 32 address bits; adr[1:0] SHALL be ignored.

Reset
REQ-020 Asserting reset SHALL immediately force IDLE, all outputs to 0, the latches to 0 and the timeout counter to 0, including mid-transaction.
REQ-021 After reset deasserts, the first stb SHALL be decoded normally.

Configuration
REQ-022 With WB_HOST_BRIDGE_TIMEOUT_EN defined, an 8-bit counter SHALL clear on REG entry and increment each REG cycle without reg_ack.
REQ-023 With WB_HOST_BRIDGE_TIMEOUT_EN defined, reaching TIMEOUT SHALL drop reg_cs and go to ERR.
REQ-024 With WB_HOST_BRIDGE_TIMEOUT_EN defined, if reg_ack and timeout coincide, reg_ack SHALL take priority (ACK).
REQ-025 Without WB_HOST_BRIDGE_TIMEOUT_EN, no counter SHALL exist and REG SHALL wait indefinitely for reg_ack or cyc drop.

Structure
REQ-026 Package wb_host_bridge_pkg SHALL hold the state enum, REG_WIN_SIZE=256 and default address-map constants.
REQ-027 The block SHALL be a single module with no sub-module; the timeout counter is inline.

Verification
REQ-028 A bench SHALL write 0xDEADBEEF to 0x10 with sel=4'b0011 -> mem_wren=4'b0011 and mem_addr=4 for one cycle, ack at N+2, wbm_dat_i=0.
REQ-029 A bench SHALL read 0x10 with BRAM returning 0x1234_5678 -> ack at N+2 with wbm_dat_i=0x1234_5678.
REQ-030 A bench SHALL write 0x5A to 0x1004 with reg_ack after 3 cycles -> reg_cs high 3 cycles, reg_addr=4, reg_wr=1, one-cycle ack after.
REQ-031 A bench SHALL access 0x2000 -> wbm_err_i high one cycle at N+1, with no mem or reg strobes.
REQ-032 With the macro defined and reg_ack never asserted, a bench SHALL see err after 255 REG cycles; without the macro, no err and reg_cs held.
REQ-033 A bench SHALL assert reset during REG or drop cyc during REG -> IDLE, all outputs 0, no ack, next read served correctly.

Source files
------------

// File: rtl/wb_host_bridge_pkg.sv
// Shared types and address-map defaults for the Wishbone-to-BRAM/register bridge.
package wb_host_bridge_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MEM,
        ST_REG,
        ST_ACK,
        ST_ERR
    } state_t;

    localparam int          REG_WIN_SIZE     = 256;
    localparam int          DEFAULT_MEM_AW   = 12;
    localparam logic [31:0] DEFAULT_REG_BASE = 32'h0000_1000;
    localparam int          DEFAULT_TIMEOUT  = 255;

    // Unsigned offset wraps for addresses below the base, so one compare covers both ends.
    function automatic logic in_reg_window(input logic [31:0] adr, input logic [31:0] base);
        logic [31:0] off;
        off = adr - base;
        return off < 32'(REG_WIN_SIZE);
    endfunction

endpackage

// File: rtl/wb_host_bridge.sv
// Wishbone slave bridging to a BRAM window and a 256-byte register window.
// Define WB_HOST_BRIDGE_TIMEOUT_EN to bound the wait for reg_ack with an error response.
module wb_host_bridge
    import wb_host_bridge_pkg::*;
#(
    parameter int          MEM_AW   = DEFAULT_MEM_AW,
    parameter logic [31:0] REG_BASE = DEFAULT_REG_BASE,
    parameter int          TIMEOUT  = DEFAULT_TIMEOUT
) (
    input  logic              sys_clk,
    input  logic              reset,
    input  logic              wbm_cyc_o,
    input  logic              wbm_stb_o,
    input  logic [31:0]       wbm_adr_o,
    input  logic              wbm_we_o,
    input  logic [31:0]       wbm_dat_o,
    input  logic [3:0]        wbm_sel_o,
    output logic [31:0]       wbm_dat_i,
    output logic              wbm_ack_i,
    output logic              wbm_err_i,
    output logic [3:0]        mem_wren,
    output logic [MEM_AW-3:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic              reg_cs,
    output logic              reg_wr,
    output logic [7:0]        reg_addr,
    output logic [3:0]        reg_be,
    output logic [31:0]       reg_wdata,
    input  logic [31:0]       reg_rdata,
    input  logic              reg_ack
);

    state_t      state_reg;
    logic [31:0] adr_reg;
    logic [31:0] dat_reg;
    logic [31:0] rdata_reg;
    logic [3:0]  sel_reg;
    logic        we_reg;
    logic        is_mem_reg;
    logic [3:0]  mem_wren_reg;
    logic        reg_cs_reg;
    logic        reg_wr_reg;
    logic        ack_reg;
    logic        err_reg;

    logic        req;
    logic        hit_mem;
    logic        hit_reg;
    logic        unused_adr_bits;

    assign req     = wbm_cyc_o & wbm_stb_o;
    assign hit_mem = (wbm_adr_o >> MEM_AW) == 32'd0;
    assign hit_reg = in_reg_window(wbm_adr_o, REG_BASE);

`ifdef WB_HOST_BRIDGE_TIMEOUT_EN
    logic [7:0] tmo_cnt_reg;
    logic       tmo_hit;

    // Fires on the REG cycle that would bring the count to TIMEOUT.
    assign tmo_hit = ({1'b0, tmo_cnt_reg} + 9'd1) >= 9'(TIMEOUT);
`else
    localparam int UNUSED_TIMEOUT = TIMEOUT;
`endif

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            adr_reg      <= '0;
            dat_reg      <= '0;
            rdata_reg    <= '0;
            sel_reg      <= '0;
            we_reg       <= 1'b0;
            is_mem_reg   <= 1'b0;
            mem_wren_reg <= '0;
            reg_cs_reg   <= 1'b0;
            reg_wr_reg   <= 1'b0;
            ack_reg      <= 1'b0;
            err_reg      <= 1'b0;
`ifdef WB_HOST_BRIDGE_TIMEOUT_EN
            tmo_cnt_reg  <= '0;
`endif
        end else begin
            ack_reg      <= 1'b0;
            err_reg      <= 1'b0;
            mem_wren_reg <= '0;
            case (state_reg)
                ST_IDLE: begin
                    if (req) begin
                        adr_reg   <= wbm_adr_o;
                        we_reg    <= wbm_we_o;
                        dat_reg   <= wbm_dat_o;
                        sel_reg   <= wbm_sel_o;
                        rdata_reg <= '0;
                        if (hit_mem) begin
                            state_reg    <= ST_MEM;
                            is_mem_reg   <= 1'b1;
                            mem_wren_reg <= wbm_we_o ? wbm_sel_o : 4'b0000;
                        end else if (hit_reg) begin
                            state_reg  <= ST_REG;
                            is_mem_reg <= 1'b0;
                            reg_cs_reg <= 1'b1;
                            reg_wr_reg <= wbm_we_o;
`ifdef WB_HOST_BRIDGE_TIMEOUT_EN
                            tmo_cnt_reg <= '0;
`endif
                        end else begin
                            state_reg  <= ST_ERR;
                            is_mem_reg <= 1'b0;
                            err_reg    <= 1'b1;
                        end
                    end
                end
                // BRAM read data lands during ACK, giving the fixed two-cycle latency.
                ST_MEM: begin
                    state_reg <= ST_ACK;
                    ack_reg   <= 1'b1;
                end
                // A master abort wins over a reg_ack arriving in the same cycle.
                ST_REG: begin
                    if (!wbm_cyc_o) begin
                        state_reg  <= ST_IDLE;
                        reg_cs_reg <= 1'b0;
                        reg_wr_reg <= 1'b0;
                    end else if (reg_ack) begin
                        state_reg  <= ST_ACK;
                        rdata_reg  <= reg_rdata;
                        ack_reg    <= 1'b1;
                        reg_cs_reg <= 1'b0;
                        reg_wr_reg <= 1'b0;
                    end
`ifdef WB_HOST_BRIDGE_TIMEOUT_EN
                    else if (tmo_hit) begin
                        state_reg  <= ST_ERR;
                        err_reg    <= 1'b1;
                        reg_cs_reg <= 1'b0;
                        reg_wr_reg <= 1'b0;
                    end else begin
                        tmo_cnt_reg <= tmo_cnt_reg + 8'd1;
                    end
`endif
                end
                ST_ACK:  state_reg <= ST_IDLE;
                ST_ERR:  state_reg <= ST_IDLE;
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign mem_wren  = mem_wren_reg;
    assign mem_addr  = adr_reg[MEM_AW-1:2];
    assign mem_wdata = dat_reg;
    assign reg_cs    = reg_cs_reg;
    assign reg_wr    = reg_wr_reg;
    assign reg_addr  = {adr_reg[7:2], 2'b00};
    assign reg_be    = sel_reg;
    assign reg_wdata = dat_reg;
    assign wbm_ack_i = ack_reg;
    assign wbm_err_i = err_reg;

    // BRAM data is only valid in the ACK cycle itself, so it is muxed straight through.
    assign wbm_dat_i = (ack_reg && !we_reg) ? (is_mem_reg ? mem_rdata : rdata_reg) : 32'd0;

    assign unused_adr_bits = ^{adr_reg[31:MEM_AW], adr_reg[1:0]};

endmodule

// File: tb/tb_wb_host_bridge.sv
// Directed bench for wb_host_bridge: per-cycle scoreboard of expected outputs plus literal checks.
module tb_wb_host_bridge;

    localparam int MEM_AW = 12;
    localparam int DEPTH  = 2048;
    localparam int TMO    = 255;

    logic              sys_clk   = 1'b0;
    logic              reset     = 1'b1;
    logic              wbm_cyc_o = 1'b0;
    logic              wbm_stb_o = 1'b0;
    logic [31:0]       wbm_adr_o = '0;
    logic              wbm_we_o  = 1'b0;
    logic [31:0]       wbm_dat_o = '0;
    logic [3:0]        wbm_sel_o = '0;
    logic [31:0]       wbm_dat_i;
    logic              wbm_ack_i;
    logic              wbm_err_i;
    logic [3:0]        mem_wren;
    logic [MEM_AW-3:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata = '0;
    logic              reg_cs;
    logic              reg_wr;
    logic [7:0]        reg_addr;
    logic [3:0]        reg_be;
    logic [31:0]       reg_wdata;
    logic [31:0]       reg_rdata = '0;
    logic              reg_ack   = 1'b0;

    int checks = 0;
    int errors = 0;
    int cyc_n  = 0;
    int slave_delay = 0;
    int slave_cnt   = 0;

    logic [31:0] bram      [0:1023];
    logic [31:0] model_mem [0:1023];

    // Expected outputs indexed by cycle (cycle k = period following the k-th rising edge).
    logic        exp_ack    [DEPTH];
    logic        exp_err    [DEPTH];
    logic [31:0] exp_dat    [DEPTH];
    logic        exp_mvld   [DEPTH];
    logic [3:0]  exp_wren   [DEPTH];
    logic [9:0]  exp_maddr  [DEPTH];
    logic [31:0] exp_mwdata [DEPTH];
    logic        exp_cs     [DEPTH];
    logic        exp_rwr    [DEPTH];
    logic [7:0]  exp_raddr  [DEPTH];
    logic [3:0]  exp_rbe    [DEPTH];
    logic [31:0] exp_rwdata [DEPTH];

    wb_host_bridge #(
        .MEM_AW   (MEM_AW),
        .REG_BASE (32'h0000_1000),
        .TIMEOUT  (TMO)
    ) dut (
        .sys_clk   (sys_clk),
        .reset     (reset),
        .wbm_cyc_o (wbm_cyc_o),
        .wbm_stb_o (wbm_stb_o),
        .wbm_adr_o (wbm_adr_o),
        .wbm_we_o  (wbm_we_o),
        .wbm_dat_o (wbm_dat_o),
        .wbm_sel_o (wbm_sel_o),
        .wbm_dat_i (wbm_dat_i),
        .wbm_ack_i (wbm_ack_i),
        .wbm_err_i (wbm_err_i),
        .mem_wren  (mem_wren),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .reg_cs    (reg_cs),
        .reg_wr    (reg_wr),
        .reg_addr  (reg_addr),
        .reg_be    (reg_be),
        .reg_wdata (reg_wdata),
        .reg_rdata (reg_rdata),
        .reg_ack   (reg_ack)
    );

    initial forever #5 sys_clk = ~sys_clk;

    initial forever begin
        @(posedge sys_clk);
        cyc_n++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, required finish before 200000 time units");
        $fatal(1, "watchdog expired");
    end

    // BRAM stub: byte-enabled write, registered read.
    initial forever begin
        @(posedge sys_clk);
        for (int b = 0; b < 4; b++)
            if (mem_wren[b]) bram[mem_addr][8*b +: 8] = mem_wdata[8*b +: 8];
        mem_rdata <= bram[mem_addr];
    end

    // Register slave: raises reg_ack in the slave_delay-th cycle of reg_cs (0 = never).
    initial forever begin
        @(posedge sys_clk);
        #1;
        if (reg_cs) begin
            slave_cnt++;
            reg_ack = (slave_delay != 0) && (slave_cnt == slave_delay);
        end else begin
            slave_cnt = 0;
            reg_ack   = 1'b0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h required %h", name, cyc_n, act, req);
        end
    endtask

    initial forever begin
        @(negedge sys_clk);
        if (cyc_n < DEPTH) begin
            chk("ack",   32'(wbm_ack_i), 32'(exp_ack[cyc_n]));
            chk("err",   32'(wbm_err_i), 32'(exp_err[cyc_n]));
            chk("dat_i", wbm_dat_i,      exp_dat[cyc_n]);
            chk("wren",  32'(mem_wren),  32'(exp_wren[cyc_n]));
            chk("cs",    32'(reg_cs),    32'(exp_cs[cyc_n]));
            if (exp_mvld[cyc_n]) begin
                chk("mem_addr",  32'(mem_addr), 32'(exp_maddr[cyc_n]));
                chk("mem_wdata", mem_wdata,     exp_mwdata[cyc_n]);
            end
            if (exp_cs[cyc_n]) begin
                chk("reg_wr",    32'(reg_wr),   32'(exp_rwr[cyc_n]));
                chk("reg_addr",  32'(reg_addr), 32'(exp_raddr[cyc_n]));
                chk("reg_be",    32'(reg_be),   32'(exp_rbe[cyc_n]));
                chk("reg_wdata", reg_wdata,     exp_rwdata[cyc_n]);
            end
        end
    end

    task automatic expect_mem(input int n, input logic [31:0] adr, input logic we,
                              input logic [31:0] dat, input logic [3:0] sel);
        int w;
        w = int'(adr[MEM_AW-1:2]);
        exp_mvld[n]   = 1'b1;
        exp_maddr[n]  = adr[MEM_AW-1:2];
        exp_mwdata[n] = dat;
        exp_wren[n]   = we ? sel : 4'b0000;
        exp_ack[n+1]  = 1'b1;
        if (we) begin
            for (int b = 0; b < 4; b++)
                if (sel[b]) model_mem[w][8*b +: 8] = dat[8*b +: 8];
            exp_dat[n+1] = '0;
        end else begin
            exp_dat[n+1] = model_mem[w];
        end
    endtask

    // outcome: 0 = abandoned, 1 = ack, 2 = err
    task automatic expect_reg(input int n, input int k, input int outcome, input logic [31:0] adr,
                              input logic we, input logic [31:0] dat, input logic [3:0] sel,
                              input logic [31:0] rdata);
        for (int i = 0; i < k; i++) begin
            exp_cs[n+i]     = 1'b1;
            exp_rwr[n+i]    = we;
            exp_raddr[n+i]  = {adr[7:2], 2'b00};
            exp_rbe[n+i]    = sel;
            exp_rwdata[n+i] = dat;
        end
        if (outcome == 1) begin
            exp_ack[n+k] = 1'b1;
            exp_dat[n+k] = we ? 32'd0 : rdata;
        end else if (outcome == 2) begin
            exp_err[n+k] = 1'b1;
        end
    endtask

    // Returns s = cycle index right after the edge that samples the request.
    task automatic issue(input logic [31:0] adr, input logic we, input logic [31:0] dat,
                         input logic [3:0] sel, output int s);
        @(posedge sys_clk);
        #1;
        wbm_cyc_o = 1'b1;
        wbm_stb_o = 1'b1;
        wbm_adr_o = adr;
        wbm_we_o  = we;
        wbm_dat_o = dat;
        wbm_sel_o = sel;
        s = cyc_n + 1;
    endtask

    task automatic release_bus();
        wbm_cyc_o = 1'b0;
        wbm_stb_o = 1'b0;
        wbm_we_o  = 1'b0;
    endtask

    task automatic wait_resp(input int max, output int at, output logic [31:0] d, output logic e);
        at = -1;
        d  = '0;
        e  = 1'b0;
        for (int i = 0; i < max; i++) begin
            @(negedge sys_clk);
            if (wbm_ack_i || wbm_err_i) begin
                at = cyc_n;
                d  = wbm_dat_i;
                e  = wbm_err_i;
                break;
            end
        end
        if (at < 0) begin
            checks++;
            errors++;
            $display("FAIL resp_wait: got no ack/err, required one within %0d cycles", max);
        end
        @(posedge sys_clk);
        #1;
        release_bus();
    endtask

    task automatic mem_txn(input string name, input logic [31:0] adr, input logic we,
                           input logic [31:0] dat, input logic [3:0] sel, input logic [31:0] want);
        int s, at;
        logic [31:0] d;
        logic e;
        issue(adr, we, dat, sel, s);
        expect_mem(s, adr, we, dat, sel);
        wait_resp(8, at, d, e);
        chk({name, "_lat"}, 32'(at - s), 32'd1);
        chk({name, "_dat"}, d, want);
        $display("txn %s adr=%h we=%0d sel=%b dat_i=%h", name, adr, we, sel, d);
    endtask

    task automatic reg_txn(input string name, input logic [31:0] adr, input logic we,
                           input logic [31:0] dat, input logic [3:0] sel, input int delay,
                           input logic [31:0] rdata, input logic [31:0] want);
        int s, at;
        logic [31:0] d;
        logic e;
        slave_delay = delay;
        reg_rdata   = rdata;
        issue(adr, we, dat, sel, s);
        expect_reg(s, delay, 1, adr, we, dat, sel, rdata);
        wait_resp(delay + 8, at, d, e);
        chk({name, "_lat"}, 32'(at - s), 32'(delay));
        chk({name, "_dat"}, d, want);
        $display("txn %s adr=%h we=%0d delay=%0d dat_i=%h", name, adr, we, delay, d);
    endtask

    task automatic err_txn(input string name, input logic [31:0] adr);
        int s, at;
        logic [31:0] d;
        logic e;
        issue(adr, 1'b0, 32'd0, 4'hF, s);
        exp_err[s] = 1'b1;
        wait_resp(8, at, d, e);
        chk({name, "_lat"}, 32'(at - s), 32'd0);
        chk({name, "_err"}, 32'(e), 32'd1);
        $display("txn %s adr=%h err=%0d", name, adr, e);
    endtask

    initial begin
        int s;
        logic [31:0] err_adrs [4];

        for (int i = 0; i < DEPTH; i++) begin
            exp_ack[i] = 0; exp_err[i] = 0; exp_dat[i] = 0; exp_mvld[i] = 0;
            exp_wren[i] = 0; exp_maddr[i] = 0; exp_mwdata[i] = 0; exp_cs[i] = 0;
            exp_rwr[i] = 0; exp_raddr[i] = 0; exp_rbe[i] = 0; exp_rwdata[i] = 0;
        end
        for (int i = 0; i < 1024; i++) begin
            bram[i]      = (32'(i) * 32'h0101_0101) ^ 32'h5500_00AA;
            model_mem[i] = (32'(i) * 32'h0101_0101) ^ 32'h5500_00AA;
        end
        bram[4]         = 32'h1234_5678;
        model_mem[4]    = 32'h1234_5678;
        bram[1023]      = 32'hA5A5_0FF0;
        model_mem[1023] = 32'hA5A5_0FF0;

        repeat (3) @(posedge sys_clk);
        @(negedge sys_clk);
        chk("rst_ack",  32'(wbm_ack_i), 32'd0);
        chk("rst_cs",   32'(reg_cs),    32'd0);
        chk("rst_addr", 32'(reg_addr),  32'd0);
        #1 reset = 1'b0;
        $display("txn reset released at cycle %0d", cyc_n);

        mem_txn("bram_rd",   32'h0000_0010, 1'b0, 32'd0,         4'hF,    32'h1234_5678);
        mem_txn("bram_wr",   32'h0000_0010, 1'b1, 32'hDEAD_BEEF, 4'b0011, 32'd0);
        mem_txn("bram_rb",   32'h0000_0010, 1'b0, 32'd0,         4'hF,    32'h1234_BEEF);
        mem_txn("bram_top",  32'h0000_0FFF, 1'b0, 32'd0,         4'hF,    32'hA5A5_0FF0);

        reg_txn("reg_wr",  32'h0000_1004, 1'b1, 32'h0000_005A, 4'hF, 3, 32'h1111_2222, 32'd0);
        reg_txn("reg_rd",  32'h0000_10FC, 1'b0, 32'd0,         4'hF, 1, 32'hCAFE_0001, 32'hCAFE_0001);

        err_adrs[0] = 32'h0000_2000;
        err_adrs[1] = 32'h0000_1100;
        err_adrs[2] = 32'hFFFF_1000;
        err_adrs[3] = 32'h8000_0010;
        for (int i = 0; i < 4; i++) err_txn("decode_err", err_adrs[i]);

        slave_delay = 0;
        issue(32'h0000_1020, 1'b0, 32'd0, 4'hF, s);
`ifdef WB_HOST_BRIDGE_TIMEOUT_EN
        begin
            int at;
            logic [31:0] d;
            logic e;
            expect_reg(s, TMO, 2, 32'h0000_1020, 1'b0, 32'd0, 4'hF, 32'd0);
            wait_resp(TMO + 10, at, d, e);
            chk("tmo_lat", 32'(at - s), 32'd255);
            chk("tmo_err", 32'(e), 32'd1);
            $display("txn timeout err=%0d after %0d cycles", e, at - s);
        end
`else
        expect_reg(s, 300, 0, 32'h0000_1020, 1'b0, 32'd0, 4'hF, 32'd0);
        repeat (300) @(posedge sys_clk);
        #1;
        chk("hold_cs", 32'(reg_cs), 32'd1);
        release_bus();
        repeat (3) @(posedge sys_clk);
        $display("txn no-timeout: reg_cs held 300 cycles, abandoned by master");
`endif

        // Master abort in the same cycle the slave acks.
        slave_delay = 4;
        reg_rdata   = 32'h7777_7777;
        issue(32'h0000_1008, 1'b0, 32'd0, 4'hF, s);
        expect_reg(s, 4, 0, 32'h0000_1008, 1'b0, 32'd0, 4'hF, 32'd0);
        repeat (4) @(posedge sys_clk);
        #1;
        release_bus();
        repeat (3) @(posedge sys_clk);
        $display("txn cyc drop during REG");
        mem_txn("after_drop", 32'h0000_0010, 1'b0, 32'd0, 4'hF, 32'h1234_BEEF);

        // Asynchronous reset in the fourth REG cycle.
        slave_delay = 0;
        issue(32'h0000_1010, 1'b1, 32'h0000_0077, 4'hF, s);
        expect_reg(s, 3, 0, 32'h0000_1010, 1'b1, 32'h0000_0077, 4'hF, 32'd0);
        repeat (4) @(posedge sys_clk);
        #3;
        reset = 1'b1;
        release_bus();
        @(negedge sys_clk);
        chk("midrst_cs",    32'(reg_cs),    32'd0);
        chk("midrst_addr",  32'(reg_addr),  32'd0);
        chk("midrst_wdata", reg_wdata,      32'd0);
        chk("midrst_maddr", 32'(mem_addr),  32'd0);
        @(posedge sys_clk);
        #1;
        reset = 1'b0;
        $display("txn reset during REG");
        mem_txn("after_rst", 32'h0000_0010, 1'b0, 32'd0, 4'hF, 32'h1234_BEEF);
        reg_txn("reg_rd2", 32'h0000_1040, 1'b0, 32'd0, 4'b0101, 2, 32'h0BAD_F00D, 32'h0BAD_F00D);

        repeat (3) @(posedge sys_clk);
        @(negedge sys_clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
